alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: UUID, 0, instance identifier; no functional effect.
REQ-002 Parameter: NAME, "", instance label; no functional effect.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  operation request; sampled with the op strobes and operands.
REQ-006 add, sub, not, or, nor, xor, nxor, and, nand, mul, div  input  1 each  one-hot op strobes from the command decoder.
REQ-007 a  input  8  operand A.
REQ-008 b  input  8  operand B.
REQ-009 result  output  8  low byte of the result: sum, difference, logic result, product low byte, or quotient.
REQ-010 result_hi  output  8  product high byte for mul; remainder for div; 0 for all other ops.
REQ-011 carry  output  1  carry out for add, borrow for sub, (result_hi != 0) for mul; 0 otherwise.
REQ-012 zero  output  1  high when result == 0x00 (low byte only).
REQ-013 div_zero  output  1  high when the last div had b == 0.
REQ-014 busy  output  1  high while a mul or div is iterating.
REQ-015 done  output  1  one-cycle pulse marking new, valid outputs.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-018 start SHALL be accepted only in IDLE, with at least one strobe high; at the accept edge a, b and the op are latched.
REQ-019 start in RUN or DONE SHALL be ignored; start with all strobes low SHALL be ignored.
REQ-020 Multi-hot strobes SHALL resolve by priority add > sub > not > or > nor > xor > nxor > and > nand > mul > div.
REQ-021 Single-cycle ops (add through nand) SHALL go IDLE -> DONE at the accept edge; outputs update at that same edge.
REQ-022 add: {carry, result} = a + b, 9-bit.
REQ-023 sub: result = a - b mod 256; carry = (a < b).
REQ-024 not: result = ~a.
REQ-025 or, nor, xor, nxor, and, nand: the bitwise function of a and b.
REQ-026 mul SHALL be unsigned shift-add, one bit per cycle: IDLE -> RUN at accept, 8 cycles in RUN, then DONE; {result_hi, result} = a * b.
REQ-027 div SHALL be unsigned restoring division, one bit per cycle, with the same 8-cycle RUN timing: result = a / b, result_hi = a % b.
REQ-028 div with b == 0 SHALL go IDLE -> DONE at accept, with result = 0xFF, result_hi = a, div_zero = 1.
REQ-029 div_zero SHALL be 0 after any other completed op.
REQ-030 busy = 1 exactly while in RUN.
REQ-031 done = 1 exactly while in DONE; DONE lasts one cycle and then returns to IDLE, so the minimum spacing between accepts is 2 cycles.
REQ-032 Outputs SHALL change only on entry to DONE, except busy, and hold until the next completion.
REQ-033 Intermediate iteration values SHALL NOT appear on result or result_hi.
REQ-034 The internal iteration counter SHALL be 3 bits and SHALL wrap from 7 into the exit to DONE; no RUN longer than 8 cycles.

Reset
REQ-035 rst low SHALL immediately force state IDLE and clear result, result_hi, carry, zero, div_zero, busy, done and all internal registers to 0, regardless of state.
REQ-036 An operation interrupted by reset SHALL be discarded, with no done pulse.
REQ-037 A start sampled at the first rising edge after rst returns high SHALL be accepted.

Verification
REQ-038 add, a=0xF0, b=0x20 -> the next cycle shows result=0x10, carry=1, zero=0, done=1, busy never high.
REQ-039 sub, a=0x05, b=0x07 -> result=0xFE, carry=1; then xor, a=b=0x5A -> result=0x00, zero=1, carry=0.
REQ-040 mul, 0xFF*0xFF -> busy high for 8 cycles, done in the 9th cycle, result=0x01, result_hi=0xFE, carry=1; mul, 0x0F*0x11 -> result=0xFF, result_hi=0x00, carry=0.
REQ-041 div, 0x64/0x07 -> after 8 busy cycles, result=0x0E, result_hi=0x02, div_zero=0; div, 0x33/0x00 -> next cycle result=0xFF, result_hi=0x33, div_zero=1.
REQ-042 start during mul RUN -> ignored, original product delivered; add+xor both high with a=0x01, b=0x01 -> result=0x02 (add wins).
REQ-043 rst low in the 4th RUN cycle of div -> all outputs 0 at once, no done; after release, and 0x0F, 0x3C -> result=0x0C.

Source files
------------

// File: rtl/alu_exec.sv
// Registered 8-bit ALU: single-cycle arithmetic/logic ops plus 8-step shift-add multiply
// and restoring divide, sequenced by an IDLE/RUN/DONE state machine.
module alu_exec #(
   parameter int    UUID = 0,
   parameter string NAME = ""
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       op_add,
   input  logic       op_sub,
   input  logic       op_not,
   input  logic       op_or,
   input  logic       op_nor,
   input  logic       op_xor,
   input  logic       op_nxor,
   input  logic       op_and,
   input  logic       op_nand,
   input  logic       op_mul,
   input  logic       op_div,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] result,
   output logic [7:0] result_hi,
   output logic       carry,
   output logic       zero,
   output logic       div_zero,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic [3:0] {
      SEL_NONE, SEL_ADD, SEL_SUB, SEL_NOT, SEL_OR, SEL_NOR, SEL_XOR,
      SEL_NXOR, SEL_AND, SEL_NAND, SEL_MUL, SEL_DIV
   } sel_t;

   if (UUID < 0 && NAME != "") begin : g_id_check
   end

   state_t      state_q, state_d;
   sel_t        sel;
   logic        is_div_q, is_div_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] x_q, x_d;
   logic [7:0]  y_q, y_d;
   logic [15:0] acc_q, acc_d;
   logic [7:0]  result_q, result_d, result_hi_q, result_hi_d;
   logic        carry_q, carry_d, zero_q, zero_d, div_zero_q, div_zero_d;
   logic        busy_q, busy_d, done_q, done_d;

   logic [8:0]  sum9, diff9, trial9, tdiff9;
   logic [15:0] prod_next;
   logic [7:0]  rem_next;
   logic        qbit;
   logic [7:0]  lo_val, hi_val;
   logic        c_val, dz_val, go_run;

   always_comb begin
      sel = SEL_NONE;
      if      (op_add)  sel = SEL_ADD;
      else if (op_sub)  sel = SEL_SUB;
      else if (op_not)  sel = SEL_NOT;
      else if (op_or)   sel = SEL_OR;
      else if (op_nor)  sel = SEL_NOR;
      else if (op_xor)  sel = SEL_XOR;
      else if (op_nxor) sel = SEL_NXOR;
      else if (op_and)  sel = SEL_AND;
      else if (op_nand) sel = SEL_NAND;
      else if (op_mul)  sel = SEL_MUL;
      else if (op_div)  sel = SEL_DIV;
   end

   // Results for ops that complete at the accept edge; mul and div (b != 0) iterate instead.
   always_comb begin
      sum9   = {1'b0, a} + {1'b0, b};
      diff9  = {1'b0, a} - {1'b0, b};
      lo_val = 8'h00;
      hi_val = 8'h00;
      c_val  = 1'b0;
      dz_val = 1'b0;
      go_run = 1'b0;
      case (sel)
         SEL_ADD:  {c_val, lo_val} = sum9;
         SEL_SUB:  begin lo_val = diff9[7:0]; c_val = diff9[8]; end
         SEL_NOT:  lo_val = ~a;
         SEL_OR:   lo_val = a | b;
         SEL_NOR:  lo_val = ~(a | b);
         SEL_XOR:  lo_val = a ^ b;
         SEL_NXOR: lo_val = ~(a ^ b);
         SEL_AND:  lo_val = a & b;
         SEL_NAND: lo_val = ~(a & b);
         SEL_MUL:  go_run = 1'b1;
         SEL_DIV: begin
            if (b == 8'h00) begin
               lo_val = 8'hFF;
               hi_val = a;
               dz_val = 1'b1;
            end else begin
               go_run = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // One iteration step: multiply adds the shifted multiplicand, divide shifts in a dividend bit.
   always_comb begin
      prod_next = acc_q + (y_q[0] ? x_q : 16'h0000);
      trial9    = {acc_q[7:0], y_q[7]};
      tdiff9    = trial9 - {1'b0, x_q[7:0]};
      qbit      = (trial9 >= {1'b0, x_q[7:0]});
      rem_next  = qbit ? tdiff9[7:0] : trial9[7:0];
   end

   always_comb begin
      state_d     = state_q;
      is_div_d    = is_div_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      y_d         = y_q;
      acc_d       = acc_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      div_zero_d  = div_zero_q;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && sel != SEL_NONE) begin
               if (go_run) begin
                  state_d  = RUN;
                  busy_d   = 1'b1;
                  is_div_d = (sel == SEL_DIV);
                  cnt_d    = 3'd0;
                  acc_d    = 16'h0000;
                  x_d      = (sel == SEL_DIV) ? {8'h00, b} : {8'h00, a};
                  y_d      = (sel == SEL_DIV) ? a : b;
               end else begin
                  state_d     = DONE;
                  done_d      = 1'b1;
                  result_d    = lo_val;
                  result_hi_d = hi_val;
                  carry_d     = c_val;
                  div_zero_d  = dz_val;
               end
            end
         end
         RUN: begin
            busy_d = 1'b1;
            cnt_d  = cnt_q + 3'd1;
            if (is_div_q) begin
               y_d   = {y_q[6:0], qbit};
               acc_d = {8'h00, rem_next};
            end else begin
               acc_d = prod_next;
               x_d   = {x_q[14:0], 1'b0};
               y_d   = {1'b0, y_q[7:1]};
            end
            if (cnt_q == 3'd7) begin
               state_d     = DONE;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               div_zero_d  = 1'b0;
               result_d    = is_div_q ? y_d : prod_next[7:0];
               result_hi_d = is_div_q ? rem_next : prod_next[15:8];
               carry_d     = is_div_q ? 1'b0 : (prod_next[15:8] != 8'h00);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (done_d) zero_d = (result_d == 8'h00);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         is_div_q    <= 1'b0;
         cnt_q       <= 3'd0;
         x_q         <= 16'h0000;
         y_q         <= 8'h00;
         acc_q       <= 16'h0000;
         result_q    <= 8'h00;
         result_hi_q <= 8'h00;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         div_zero_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_div_q    <= is_div_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         acc_q       <= acc_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         div_zero_q  <= div_zero_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign div_zero  = div_zero_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_alu_exec.sv
// Randomized and directed checks of alu_exec against an arithmetic reference model.
module tb_alu_exec;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [10:0] strb = '0;
   logic [7:0]  a = 8'h00, b = 8'h00;
   logic [7:0]  result, result_hi;
   logic        carry, zero, div_zero, busy, done;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_exec #(.UUID(1), .NAME("tb")) dut (
      .clk(clk), .rst(rst_n), .start(start),
      .op_add(strb[0]), .op_sub(strb[1]), .op_not(strb[2]), .op_or(strb[3]),
      .op_nor(strb[4]), .op_xor(strb[5]), .op_nxor(strb[6]), .op_and(strb[7]),
      .op_nand(strb[8]), .op_mul(strb[9]), .op_div(strb[10]),
      .a(a), .b(b), .result(result), .result_hi(result_hi), .carry(carry),
      .zero(zero), .div_zero(div_zero), .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: lowest set strobe wins; values from plain integer arithmetic.
   function automatic void model(input logic [10:0] s, input logic [7:0] x, input logic [7:0] y,
                                 output logic [7:0] r, output logic [7:0] rh,
                                 output logic c, output logic dz, output int lat);
      int k, sum, p;
      k = -1;
      for (int i = 0; i < 11; i++) if (s[i] && k < 0) k = i;
      r = 8'h00; rh = 8'h00; c = 1'b0; dz = 1'b0; lat = 1;
      case (k)
         0: begin sum = int'(x) + int'(y); r = 8'(sum % 256); c = (sum > 255); end
         1: begin sum = int'(x) - int'(y) + 256; r = 8'(sum % 256); c = (x < y); end
         2: r = ~x;
         3: r = x | y;
         4: r = ~(x | y);
         5: r = x ^ y;
         6: r = ~(x ^ y);
         7: r = x & y;
         8: r = ~(x & y);
         9: begin
            p = int'(x) * int'(y);
            r = 8'(p % 256); rh = 8'(p / 256); c = (rh != 0); lat = 9;
         end
         10: begin
            if (y == 0) begin r = 8'hFF; rh = x; dz = 1'b1; end
            else begin r = 8'(int'(x) / int'(y)); rh = 8'(int'(x) % int'(y)); lat = 9; end
         end
         default: ;
      endcase
   endfunction

   task automatic run_op(input string name, input logic [10:0] s, input logic [7:0] x,
                         input logic [7:0] y, input int poke);
      logic [7:0] er, erh;
      logic       ec, edz;
      int         lat, busy_n, done_at;
      model(s, x, y, er, erh, ec, edz, lat);
      busy_n = 0;
      done_at = -1;
      @(negedge clk);
      start = 1'b1; strb = s; a = x; b = y;
      @(negedge clk);
      start = 1'b0; strb = '0; a = 8'($urandom); b = 8'($urandom);
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (cyc > 0) begin
            @(negedge clk);
            start = 1'b0; strb = '0;
         end
         if (done) begin done_at = cyc; break; end
         if (busy) busy_n++;
         if (cyc == poke) begin start = 1'b1; strb = 11'h001; a = 8'h01; b = 8'h01; end
      end
      check({name, ".latency"}, done_at, lat - 1);
      check({name, ".busy_cycles"}, busy_n, lat - 1);
      check({name, ".busy_at_done"}, busy, 0);
      check({name, ".result"}, result, er);
      check({name, ".result_hi"}, result_hi, erh);
      check({name, ".carry"}, carry, ec);
      check({name, ".zero"}, zero, er == 8'h00);
      check({name, ".div_zero"}, div_zero, edz);
      @(negedge clk);
      check({name, ".done_pulse"}, done, 0);
      check({name, ".hold"}, result, er);
      $display("op %s strb=%03h a=%02h b=%02h -> result=%02h hi=%02h c=%0b z=%0b dz=%0b",
               name, s, x, y, result, result_hi, carry, zero, div_zero);
   endtask

   initial begin
      logic [10:0] s;
      logic [7:0]  x, y;

      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst.result", result, 0);
      check("rst.flags", {carry, zero, div_zero, busy, done}, 0);
      rst_n = 1'b1;

      run_op("add_F0_20", 11'h001, 8'hF0, 8'h20, -1);
      run_op("sub_05_07", 11'h002, 8'h05, 8'h07, -1);
      run_op("xor_5A_5A", 11'h020, 8'h5A, 8'h5A, -1);
      run_op("mul_FF_FF", 11'h200, 8'hFF, 8'hFF, -1);
      run_op("mul_0F_11", 11'h200, 8'h0F, 8'h11, -1);
      run_op("div_64_07", 11'h400, 8'h64, 8'h07, -1);
      run_op("div_33_00", 11'h400, 8'h33, 8'h00, -1);
      run_op("mul_poke", 11'h200, 8'h12, 8'h34, 3);
      run_op("add_xor", 11'h021, 8'h01, 8'h01, -1);
      run_op("all_hot", 11'h7FE, 8'hC3, 8'h3C, -1);

      @(negedge clk);
      start = 1'b1; strb = '0; a = 8'h11; b = 8'h22;
      @(negedge clk);
      start = 1'b0;
      check("nostrobe.done", done, 0);
      check("nostrobe.busy", busy, 0);
      $display("op nostrobe ignored result=%02h", result);

      // Reset in the 4th RUN cycle of a divide, then an immediate accept after release.
      @(negedge clk);
      start = 1'b1; strb = 11'h400; a = 8'h64; b = 8'h07;
      @(negedge clk);
      start = 1'b0; strb = '0;
      repeat (3) @(negedge clk);
      check("rstrun.busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("rstrun.outputs", {result, result_hi}, 0);
      check("rstrun.flags", {carry, zero, div_zero, busy, done}, 0);
      repeat (2) begin
         @(negedge clk);
         check("rstrun.no_done", done, 0);
      end
      rst_n = 1'b1; start = 1'b1; strb = 11'h080; a = 8'h0F; b = 8'h3C;
      @(negedge clk);
      start = 1'b0; strb = '0;
      check("rstrel.done", done, 1);
      check("rstrel.result", result, 8'h0C);
      check("rstrel.div_zero", div_zero, 0);
      $display("op and_after_reset a=0f b=3c -> result=%02h", result);

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0) s = 11'($urandom);
         else s = 11'h001 << $urandom_range(0, 10);
         if (s == '0) s = 11'h200;
         x = 8'($urandom);
         y = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         run_op($sformatf("rnd%0d", n), s, x, y, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
